// File: rtl/voice_scheduler.sv
// voice_scheduler: shares one wavetable ROM across NUM_VOICES oscillator voices.
// Each frame visits every voice (address, phase step, sample accumulate), then
// pushes one gain-scaled, saturated 16-bit word to the I2S FIFO.

// Per-voice state: config registers plus phase accumulator.
module voice_slot #(
  parameter int PHASE_W = 24
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               we,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_en,
  input  logic               cfg_wave,
  input  logic               adv,
  output logic               en,
  output logic [12:0]        addr
);
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] phase;
  logic               wave;

  // config registers, writable at any time
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      inc  <= '0;
      en   <= 1'b0;
      wave <= 1'b0;
    end else if (we) begin
      inc  <= cfg_inc;
      en   <= cfg_en;
      wave <= cfg_wave;
    end
  end

  // gate edges restart the phase; otherwise step with the settings in force before any same-edge write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                      phase <= '0;
    else if (we && (cfg_en != en))  phase <= '0;
    else if (adv)                   phase <= en ? phase + inc : '0;
  end

  assign addr = {wave, phase[PHASE_W-1 -: 12]};
endmodule

module voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int ROM_LAT    = 1,
  parameter int GAIN_SHIFT = 3
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CFG_WE,
  input  logic [$clog2(NUM_VOICES)-1:0] CFG_VOICE,
  input  logic [PHASE_W-1:0]            CFG_INC,
  input  logic                          CFG_EN,
  input  logic                          CFG_WAVE,
  input  logic                          FIFO_FULL,
  input  logic [15:0]                   ROM_SAMPLE,
  output logic [12:0]                   ROM_ADDR,
  output logic                          FIFO_WRITE,
  output logic [15:0]                   AUDIO_OUT,
  output logic                          BUSY
);
  localparam int VW        = $clog2(NUM_VOICES);
  localparam int MIX_W     = 16 + VW;
  localparam int WCW       = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
  localparam int WAIT_LAST = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;
  localparam logic signed [MIX_W-1:0] SMAX = {{(VW+1){1'b0}}, {15{1'b1}}};
  localparam logic signed [MIX_W-1:0] SMIN = {{(VW+1){1'b1}}, {15{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_OUTPUT} state_t;

  state_t                          state, nstate;
  logic [VW-1:0]                   v, v_nxt;
  logic [WCW-1:0]                  wcnt;
  logic signed [MIX_W-1:0]         mix, mix_sh;
  logic [15:0]                     sat16;
  logic                            issue, accum, push, last, ld_first, ld_next;
  logic [NUM_VOICES-1:0]           v_en, v_we, v_adv;
  logic [NUM_VOICES-1:0][12:0]     v_addr;

  genvar i;
  generate
    for (i = 0; i < NUM_VOICES; i++) begin : g_voice
      assign v_we[i]  = CFG_WE && (CFG_VOICE == VW'(i));
      assign v_adv[i] = issue && (v == VW'(i));
      voice_slot #(.PHASE_W(PHASE_W)) u_slot (
        .CLK      (CLK),
        .RESET    (RESET),
        .we       (v_we[i]),
        .cfg_inc  (CFG_INC),
        .cfg_en   (CFG_EN),
        .cfg_wave (CFG_WAVE),
        .adv      (v_adv[i]),
        .en       (v_en[i]),
        .addr     (v_addr[i])
      );
    end
  endgenerate

  assign v_nxt  = v + VW'(1);
  assign last   = (v == VW'(NUM_VOICES - 1));
  assign mix_sh = mix >>> GAIN_SHIFT;
  assign sat16  = (mix_sh > SMAX) ? 16'h7FFF :
                  (mix_sh < SMIN) ? 16'h8000 : mix_sh[15:0];

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= nstate;
  end

  // next-state logic; FIFO_FULL only holds the frame at its two ends
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (!FIFO_FULL) nstate = S_ISSUE;
      S_ISSUE:  nstate = (ROM_LAT > 1) ? S_WAIT : S_ACCUM;
      S_WAIT:   if (wcnt == WCW'(WAIT_LAST)) nstate = S_ACCUM;
      S_ACCUM:  nstate = last ? S_OUTPUT : S_ISSUE;
      S_OUTPUT: if (!FIFO_FULL) nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    BUSY     = (state != S_IDLE);
    issue    = (state == S_ISSUE);
    accum    = (state == S_ACCUM);
    push     = (state == S_OUTPUT) && !FIFO_FULL;
    ld_first = (state == S_IDLE) && !FIFO_FULL;
    ld_next  = accum && !last;
  end

  // voice index, ROM wait counter and mix accumulator
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v    <= '0;
      wcnt <= '0;
      mix  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          v   <= '0;
          mix <= '0;
        end
        S_ISSUE: wcnt <= '0;
        S_WAIT:  wcnt <= wcnt + WCW'(1);
        S_ACCUM: begin
          if (v_en[v]) mix <= mix + $signed({{VW{ROM_SAMPLE[15]}}, ROM_SAMPLE});
          if (!last)   v   <= v_nxt;
        end
        default: ;
      endcase
    end
  end

  // ROM address is loaded one cycle ahead of each ISSUE and held otherwise
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         ROM_ADDR <= '0;
    else if (ld_first) ROM_ADDR <= v_addr[0];
    else if (ld_next)  ROM_ADDR <= v_addr[v_nxt];
  end

  // FIFO push strobe and held output word
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FIFO_WRITE <= 1'b0;
      AUDIO_OUT  <= '0;
    end else begin
      FIFO_WRITE <= push;
      if (push) AUDIO_OUT <= sat16;
    end
  end
endmodule
